// File: rtl/rom_loader_pkg.sv
// Shared types and width helpers for the byte-stream ROM loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  function automatic int bytes_per_word(input int mem_w);
    return mem_w / 8;
  endfunction

  // A single-lane word still needs a 1-bit lane index to keep ports legal.
  function automatic int lane_idx_w(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/rom_loader_packer.sv
// Packs accepted stream bytes little-endian into one memory word and tracks filled lanes.
module rom_loader_packer
  import rom_loader_pkg::*;
#(
  parameter int MEM_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic [7:0]         data_byte,
  output logic [MEM_W-1:0]   word,
  output logic [MEM_W/8-1:0] be,
  output logic               last_lane
);

  localparam int BPW = bytes_per_word(MEM_W);
  localparam int LW  = lane_idx_w(BPW);

  logic [LW-1:0] lane_r;

  assign last_lane = (lane_r == LW'(BPW - 1));

  // Lane fill: clear has priority so a word is never mixed across two writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_r <= {LW{1'b0}};
      word   <= {MEM_W{1'b0}};
      be     <= {BPW{1'b0}};
    end else if (clear) begin
      lane_r <= {LW{1'b0}};
      word   <= {MEM_W{1'b0}};
      be     <= {BPW{1'b0}};
    end else if (load) begin
      for (int i = 0; i < BPW; i++) begin
        if (lane_r == LW'(i)) begin
          word[i*8 +: 8] <= data_byte;
          be[i]          <= 1'b1;
        end
      end
      lane_r <= last_lane ? {LW{1'b0}} : lane_r + LW'(1);
    end else begin
      lane_r <= lane_r;
      word   <= word;
      be     <= be;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Streams bytes into word-wide memory writes with optional header skip and a 16-bit payload sum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int MEM_W     = 8,
  parameter int HDR_BYTES = 0,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W:0]    romsize,
  input  logic [7:0]         indata,
  input  logic               indata_clk,
  output logic               indata_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [MEM_W-1:0]   mem_data,
  output logic [MEM_W/8-1:0] mem_be,
  output logic               mem_write,
  input  logic               mem_ack,
  output logic               done,
  output logic               error,
  output logic [15:0]        checksum
);

  localparam int BPW   = bytes_per_word(MEM_W);
  localparam int HDR_W = (HDR_BYTES > 0) ? $clog2(HDR_BYTES + 1) : 1;
  localparam logic [63:0] MAX_BYTES = 64'(BPW) * ((64'd1 << ADDR_W) - 64'(BASE_ADDR));
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [ADDR_W:0]   bytes_left;
  logic [HDR_W-1:0]  hdr_left;
  logic              idle_like;
  logic              pack_clear;
  logic              pack_load;
  logic              last_lane;

  assign indata_ready = (state == S_HEADER) || (state == S_LOAD);
  assign idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign pack_clear   = (idle_like && start) || ((state == S_WRITE) && mem_ack && !indata_clk);
  assign pack_load    = (state == S_LOAD) && indata_clk;

  rom_loader_packer #(.MEM_W(MEM_W)) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pack_clear),
    .load      (pack_load),
    .data_byte (indata),
    .word      (mem_data),
    .be        (mem_be),
    .last_lane (last_lane)
  );

  // Control FSM; a strobe during WRITE is an overrun and beats a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bytes_left <= {(ADDR_W+1){1'b0}};
      hdr_left   <= {HDR_W{1'b0}};
      mem_addr   <= BASE;
      mem_write  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            bytes_left <= romsize;
            hdr_left   <= HDR_W'(HDR_BYTES);
            checksum   <= 16'd0;
            mem_addr   <= BASE;
            done       <= 1'b0;
            error      <= 1'b0;
            if (64'(romsize) > MAX_BYTES) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if (HDR_BYTES > 0) begin
              state <= S_HEADER;
            end else if (romsize == {(ADDR_W+1){1'b0}}) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_HEADER: begin
          if (indata_clk) begin
            hdr_left <= hdr_left - HDR_W'(1);
            if (hdr_left == HDR_W'(1)) begin
              if (bytes_left == {(ADDR_W+1){1'b0}}) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (indata_clk) begin
            checksum   <= checksum + {8'd0, indata};
            bytes_left <= bytes_left - (ADDR_W+1)'(1);
            if (last_lane || (bytes_left == (ADDR_W+1)'(1))) begin
              state     <= S_WRITE;
              mem_write <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (indata_clk) begin
            state     <= S_ERROR;
            error     <= 1'b1;
            mem_write <= 1'b0;
          end else if (mem_ack) begin
            mem_write <= 1'b0;
            mem_addr  <= mem_addr + ADDR_W'(1);
            if (bytes_left != {(ADDR_W+1){1'b0}}) begin
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: three parameterisations share one stream and one ack responder.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b, start_c;
  logic [22:0] romsize;
  logic [7:0]  indata;
  logic        indata_clk;
  logic        mem_ack;

  logic        ready_a, write_a, done_a, error_a;
  logic [3:0]  addr_a;
  logic [7:0]  data_a;
  logic [0:0]  be_a;
  logic [15:0] sum_a;

  logic        ready_b, write_b, done_b, error_b;
  logic [21:0] addr_b;
  logic [15:0] data_b;
  logic [1:0]  be_b;
  logic [15:0] sum_b;

  logic        ready_c, write_c, done_c, error_c;
  logic [21:0] addr_c;
  logic [7:0]  data_c;
  logic [0:0]  be_c;
  logic [15:0] sum_c;

  int          sel;
  logic        ack_en;
  logic        force_ack;
  logic        cur_ready, cur_write, cur_done, cur_error;
  logic [31:0] cur_addr;
  logic [15:0] cur_data;
  logic [1:0]  cur_be;
  logic [15:0] cur_sum;

  logic [31:0] log_addr[$];
  logic [15:0] log_data[$];
  logic [1:0]  log_be[$];
  int          base;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(4), .MEM_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .romsize(romsize[4:0]),
    .indata(indata), .indata_clk(indata_clk), .indata_ready(ready_a),
    .mem_addr(addr_a), .mem_data(data_a), .mem_be(be_a), .mem_write(write_a),
    .mem_ack(mem_ack), .done(done_a), .error(error_a), .checksum(sum_a));

  rom_loader #(.MEM_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .romsize(romsize),
    .indata(indata), .indata_clk(indata_clk), .indata_ready(ready_b),
    .mem_addr(addr_b), .mem_data(data_b), .mem_be(be_b), .mem_write(write_b),
    .mem_ack(mem_ack), .done(done_b), .error(error_b), .checksum(sum_b));

  rom_loader #(.HDR_BYTES(16), .BASE_ADDR(5)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .romsize(romsize),
    .indata(indata), .indata_clk(indata_clk), .indata_ready(ready_c),
    .mem_addr(addr_c), .mem_data(data_c), .mem_be(be_c), .mem_write(write_c),
    .mem_ack(mem_ack), .done(done_c), .error(error_c), .checksum(sum_c));

  // View of whichever instance the current test drives.
  always_comb begin
    cur_ready = 1'b0; cur_write = 1'b0; cur_done = 1'b0; cur_error = 1'b0;
    cur_addr = 32'd0; cur_data = 16'd0; cur_be = 2'd0; cur_sum = 16'd0;
    case (sel)
      1: begin
        cur_ready = ready_b; cur_write = write_b; cur_done = done_b; cur_error = error_b;
        cur_addr = 32'(addr_b); cur_data = data_b; cur_be = be_b; cur_sum = sum_b;
      end
      2: begin
        cur_ready = ready_c; cur_write = write_c; cur_done = done_c; cur_error = error_c;
        cur_addr = 32'(addr_c); cur_data = 16'(data_c); cur_be = 2'(be_c); cur_sum = sum_c;
      end
      default: begin
        cur_ready = ready_a; cur_write = write_a; cur_done = done_a; cur_error = error_a;
        cur_addr = 32'(addr_a); cur_data = 16'(data_a); cur_be = 2'(be_a); cur_sum = sum_a;
      end
    endcase
  end

  // Memory responder: acks the cycle after a write appears and logs what it acked.
  always @(negedge clk) begin
    if (ack_en) begin
      if (cur_write && !mem_ack) begin
        mem_ack = 1'b1;
        log_addr.push_back(cur_addr);
        log_data.push_back(cur_data);
        log_be.push_back(cur_be);
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = force_ack;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int which, input logic [22:0] size);
    sel     = which;
    base    = log_addr.size();
    romsize = size;
    case (which)
      1:       start_b = 1'b1;
      2:       start_c = 1'b1;
      default: start_a = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) begin
      check_val("ready_timeout", 32'(cur_ready), 32'd1);
    end else begin
      indata = b; indata_clk = 1'b1;
      @(negedge clk);
      indata_clk = 1'b0;
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!cur_done && !cur_error && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic int nwr();
    return log_addr.size() - base;
  endfunction

  initial begin
    logic [7:0] t1 [4];
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    romsize = 23'd0; indata = 8'd0; indata_clk = 1'b0;
    mem_ack = 1'b0; force_ack = 1'b0; ack_en = 1'b1; sel = 0; base = 0;
    tick(3);
    check_val("rst_addr", cur_addr, 32'd0);
    check_val("rst_write", 32'(cur_write), 32'd0);
    check_val("rst_done", 32'(cur_done), 32'd0);
    check_val("rst_error", 32'(cur_error), 32'd0);
    check_val("rst_sum", 32'(cur_sum), 32'd0);
    check_val("rst_c_addr", 32'(addr_c), 32'd5);
    reset_n = 1'b1;
    tick(2);
    check_val("idle_ready", 32'(cur_ready), 32'd0);

    // 8-bit words, four bytes, immediate ack
    do_start(0, 23'd4);
    for (int i = 0; i < 4; i++) send_byte(t1[i]);
    wait_end();
    check_val("t1_nwr", 32'(nwr()), 32'd4);
    for (int i = 0; i < 4 && i < nwr(); i++) begin
      check_val("t1_addr", log_addr[base+i], 32'(i));
      check_val("t1_data", 32'(log_data[base+i]), 32'(t1[i]));
      check_val("t1_be", 32'(log_be[base+i]), 32'd1);
    end
    check_val("t1_sum", 32'(cur_sum), 32'h00AA);
    check_val("t1_done", 32'(cur_done), 32'd1);
    check_val("t1_error", 32'(cur_error), 32'd0);
    indata = 8'hFF; indata_clk = 1'b1; tick(1); indata_clk = 1'b0; tick(1);
    check_val("done_strobe_done", 32'(cur_done), 32'd1);
    check_val("done_strobe_err", 32'(cur_error), 32'd0);
    check_val("done_strobe_sum", 32'(cur_sum), 32'h00AA);

    // 16-bit words with a trailing partial word
    do_start(1, 23'd3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_end();
    check_val("t2_nwr", 32'(nwr()), 32'd2);
    if (nwr() >= 2) begin
      check_val("t2_addr0", log_addr[base], 32'd0);
      check_val("t2_data0", 32'(log_data[base]), 32'h0201);
      check_val("t2_be0", 32'(log_be[base]), 32'd3);
      check_val("t2_addr1", log_addr[base+1], 32'd1);
      check_val("t2_data1", 32'(log_data[base+1]), 32'h0003);
      check_val("t2_be1", 32'(log_be[base+1]), 32'd1);
    end
    check_val("t2_sum", 32'(cur_sum), 32'h0006);
    check_val("t2_done", 32'(cur_done), 32'd1);

    // 16-byte header skipped, payload lands at BASE_ADDR=5
    do_start(2, 23'd2);
    check_val("t3_hdr_ready", 32'(cur_ready), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
    check_val("t3_hdr_nwr", 32'(nwr()), 32'd0);
    check_val("t3_hdr_sum", 32'(cur_sum), 32'd0);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_end();
    check_val("t3_nwr", 32'(nwr()), 32'd2);
    if (nwr() >= 2) begin
      check_val("t3_addr0", log_addr[base], 32'd5);
      check_val("t3_data0", 32'(log_data[base]), 32'h005A);
      check_val("t3_addr1", log_addr[base+1], 32'd6);
      check_val("t3_data1", 32'(log_data[base+1]), 32'h00A5);
    end
    check_val("t3_sum", 32'(cur_sum), 32'h00FF);
    check_val("t3_done", 32'(cur_done), 32'd1);

    // ADDR_W=4: 17 bytes too many, 0 bytes trivially done, 16 bytes fills the space
    do_start(0, 23'd17);
    check_val("t4_err", 32'(cur_error), 32'd1);
    check_val("t4_err_done", 32'(cur_done), 32'd0);
    check_val("t4_err_write", 32'(cur_write), 32'd0);
    tick(3);
    check_val("t4_err_nwr", 32'(nwr()), 32'd0);
    do_start(0, 23'd0);
    check_val("t4_zero_done", 32'(cur_done), 32'd1);
    check_val("t4_zero_err", 32'(cur_error), 32'd0);
    tick(2);
    check_val("t4_zero_nwr", 32'(nwr()), 32'd0);
    do_start(0, 23'd16);
    check_val("t4_full_err", 32'(cur_error), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    wait_end();
    check_val("t4_full_nwr", 32'(nwr()), 32'd16);
    if (nwr() >= 16) check_val("t4_full_last", log_addr[base+15], 32'd15);
    check_val("t4_full_sum", 32'(cur_sum), 32'h0078);
    check_val("t4_full_done", 32'(cur_done), 32'd1);

    // Ack withheld: write must hold steady, then a strobe overruns
    ack_en = 1'b0;
    do_start(0, 23'd2);
    send_byte(8'h3C);
    for (int i = 0; i < 5; i++) begin
      check_val("t5_hold_write", 32'(cur_write), 32'd1);
      check_val("t5_hold_data", 32'(cur_data), 32'h003C);
      check_val("t5_hold_addr", cur_addr, 32'd0);
      tick(1);
    end
    indata = 8'h77; indata_clk = 1'b1; tick(1); indata_clk = 1'b0;
    check_val("t5_ovr_err", 32'(cur_error), 32'd1);
    check_val("t5_ovr_done", 32'(cur_done), 32'd0);
    check_val("t5_ovr_write", 32'(cur_write), 32'd0);
    check_val("t5_ovr_sum", 32'(cur_sum), 32'h003C);
    force_ack = 1'b1; tick(1); force_ack = 1'b0; tick(1);
    check_val("t5_stray_ack_addr", cur_addr, 32'd0);
    check_val("t5_stray_ack_err", 32'(cur_error), 32'd1);
    ack_en = 1'b1;

    // Reset in the middle of a load, then a clean reload
    do_start(0, 23'd4);
    send_byte(8'hAA); send_byte(8'hBB);
    tick(3);
    check_val("t6_pre_nwr", 32'(nwr()), 32'd2);
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_addr", cur_addr, 32'd0);
    check_val("t6_rst_data", 32'(cur_data), 32'd0);
    check_val("t6_rst_be", 32'(cur_be), 32'd0);
    check_val("t6_rst_write", 32'(cur_write), 32'd0);
    check_val("t6_rst_sum", 32'(cur_sum), 32'd0);
    check_val("t6_rst_ready", 32'(cur_ready), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check_val("t6_post_nwr", 32'(nwr()), 32'd2);
    do_start(0, 23'd4);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    wait_end();
    check_val("t6_nwr", 32'(nwr()), 32'd4);
    if (nwr() >= 1) check_val("t6_addr0", log_addr[base], 32'd0);
    check_val("t6_sum", 32'(cur_sum), 32'h000A);
    check_val("t6_done", 32'(cur_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
